sram_rr_arbiter: RTL and testbench
==================================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NPORT, default 3, meaning the number of requester ports.
REQ-002 The block SHALL have parameter AW, default 22, meaning the SRAM word-address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-004 The block SHALL have parameter TMO, default 255, meaning the watchdog limit in cycles per SRAM phase.
REQ-005 clk  in  1  single clock; all state updates on posedge only.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 req_cs  in  NPORT  per-port request, level held until that port's ack.
REQ-008 req_we  in  NPORT  per-port write enable (1 = write).
REQ-009 req_addr  in  NPORT*AW  per-port packed address.
REQ-010 req_wdata  in  NPORT*DW  per-port packed write data.
REQ-011 req_bin  in  NPORT*4  per-port packed byte enables.
REQ-012 req_ack  out  NPORT  one-cycle completion pulse per port.
REQ-013 req_rdata  out  NPORT*DW  per-port read data, held until the next completion on that port.
REQ-014 sram_addr, sram_data_write, sram_bin, sram_we, sram_cs  out  AW/DW/4/1/1  SRAM controller command.
REQ-015 sram_data_out  in  DW  SRAM read data.
REQ-016 sram_ready  in  1  controller idle/done level.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 tmo_err  out  1  sticky watchdog flag.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RESP.
REQ-020 In IDLE, with any req_cs bit high and sram_ready=1, the block SHALL grant the first requesting port, searching from (last+1) mod NPORT upward with wrap.
REQ-021 The grant SHALL latch that port's we/addr/wdata/bin, drive sram_cs=1 with the latched command on the next cycle, and enter ISSUE.
REQ-022 In ISSUE, sram_cs SHALL remain 1 until sram_ready is sampled 0; sram_cs SHALL then drop to 0 the next cycle and the FSM SHALL enter WAIT_DONE.
REQ-023 In WAIT_DONE, on sram_ready=1 the block SHALL capture sram_data_out into req_rdata of the granted port (reads only; writes leave it unchanged) and enter RESP.
REQ-024 In RESP, req_ack[granted] SHALL pulse for exactly one cycle, last SHALL be set to the granted port, and the FSM SHALL return to IDLE.
REQ-025 Minimum service time SHALL be grant + 1 ISSUE + 1 WAIT_DONE + 1 RESP, i.e. 4 cycles.
REQ-026 A port SHALL not be re-granted in the IDLE cycle immediately following its ack.
REQ-027 sram_addr/sram_data_write/sram_we/sram_bin SHALL be stable from ISSUE entry to RESP exit.
REQ-028 A req_cs drop after grant SHALL NOT abort the transaction; the ack SHALL still pulse.
REQ-029 Request-input changes after grant SHALL be ignored until the next grant.
REQ-030 With sram_ready=0 in IDLE, no grant SHALL occur.
REQ-031 The watchdog SHALL count cycles in ISSUE or WAIT_DONE; reaching TMO SHALL set tmo_err, force sram_cs=0, ack the port with req_rdata unchanged, and return to IDLE.
REQ-032 At most one req_ack bit SHALL be high in any cycle.

Reset
REQ-033 On rst=0 the block SHALL immediately set: state=IDLE, last=NPORT-1 (so port 0 wins first), sram_cs=0, sram_we=0, sram_addr=0, sram_data_write=0, sram_bin=0, req_ack=0, req_rdata=0, busy=0, tmo_err=0, watchdog=0.
REQ-034 A reset mid-transaction SHALL drop sram_cs immediately and SHALL produce no ack after release.
REQ-035 tmo_err SHALL clear only on reset.

Structure
REQ-036 State encodings, default widths and TMO SHALL reside in the shared package sram_pkg.
REQ-037 The round-robin next-grant search SHALL be one combinational sub-module, rr_pick (inputs: request vector and last; outputs: one-hot grant and valid).

Verification
REQ-038 Single read: port1 cs, we=0, addr=0x00010; model drops ready 1 cycle after cs and raises it 3 cycles later with 0xDEADBEEF -> sram_cs held exactly until the ready fall, ack[1] one cycle, req_rdata[1]=0xDEADBEEF.
REQ-039 All three ports requesting continuously from reset -> grant order 0,1,2,0,1,2; no port granted twice in a row.
REQ-040 Write: port2 we=1, bin=0x3, wdata=0x12345678 -> sram_we=1, sram_bin=0x3, data stable through ISSUE; ack[2] pulses; req_rdata[2] unchanged.
REQ-041 Port0 drops cs one cycle after grant -> the transaction completes and ack[0] pulses once.
REQ-042 Model never lowers sram_ready -> after TMO cycles: tmo_err=1, sram_cs=0, ack pulses, FSM returns to IDLE.
REQ-043 Assert rst in WAIT_DONE -> sram_cs=0 within the same cycle and all outputs at their reset values.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding, default widths and watchdog limit for the SRAM arbiter
package sram_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_e;
    localparam int NPORT_DEF = 3;
    localparam int AW_DEF    = 22;
    localparam int DW_DEF    = 32;
    localparam int BW        = 4;
    localparam int TMO_DEF   = 255;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search from last+1 with wrap (in: req, last; out: one-hot gnt, valid)
module rr_pick #(
    parameter int N  = 3,
    parameter int LW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [LW-1:0] k;
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = LW'((int'(last) + i) % N);
            if (!valid && req[k]) begin
                gnt[k] = 1'b1;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin arbiter of NPORT requesters onto one SRAM controller (req_* in, req_ack/req_rdata out, sram_* command out, busy, sticky tmo_err)
module sram_rr_arbiter
    import sram_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_cs,
    input  logic [NPORT-1:0]    req_we,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT*DW-1:0] req_wdata,
    input  logic [NPORT*BW-1:0] req_bin,
    output logic [NPORT-1:0]    req_ack,
    output logic [NPORT*DW-1:0] req_rdata,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_data_write,
    output logic [BW-1:0]       sram_bin,
    output logic                sram_we,
    output logic                sram_cs,
    input  logic [DW-1:0]       sram_data_out,
    input  logic                sram_ready,
    output logic                busy,
    output logic                tmo_err
);
    localparam int LW = idx_w(NPORT);
    localparam int CW = $clog2(TMO + 1);

    state_e              state_q, state_d;
    logic [LW-1:0]       last_q, last_d, gnt_q, gnt_d, pick_idx;
    logic                just_q, just_d, cs_q, cs_d, we_q, we_d, tmo_q, tmo_d;
    logic [CW-1:0]       wd_q, wd_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdat_q, wdat_d;
    logic [BW-1:0]       bin_q, bin_d;
    logic [NPORT-1:0]    ack_q, ack_d, req_m, pick_oh;
    logic [DW-1:0]       rdata_q [NPORT];
    logic [DW-1:0]       rdata_d [NPORT];
    logic                pick_vld, wd_hit;

    // the port acked last cycle sits out the IDLE cycle that follows its ack
    assign req_m  = req_cs & ~(just_q ? (NPORT'(1) << last_q) : '0);
    assign wd_hit = (wd_q == CW'(TMO - 1));

    rr_pick #(.N(NPORT), .LW(LW)) u_pick (
        .req   (req_m),
        .last  (last_q),
        .gnt   (pick_oh),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NPORT; i++) if (pick_oh[i]) pick_idx = LW'(i);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        just_d  = 1'b0;
        cs_d    = cs_q;
        we_d    = we_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        bin_d   = bin_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (pick_vld && sram_ready) begin
                gnt_d   = pick_idx;
                we_d    = req_we[pick_idx];
                addr_d  = req_addr[int'(pick_idx)*AW +: AW];
                wdat_d  = req_wdata[int'(pick_idx)*DW +: DW];
                bin_d   = req_bin[int'(pick_idx)*BW +: BW];
                cs_d    = 1'b1;
                wd_d    = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d = wd_q + CW'(1);
                if (!sram_ready) begin
                    cs_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else if (wd_hit) begin
                    tmo_d        = 1'b1;
                    cs_d         = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = RESP;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + CW'(1);
                if (sram_ready) begin
                    if (!we_q) rdata_d[gnt_q] = sram_data_out;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = RESP;
                end else if (wd_hit) begin
                    tmo_d        = 1'b1;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                last_d  = gnt_q;
                just_d  = 1'b1;
                wd_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= LW'(NPORT - 1);
            gnt_q   <= '0;
            just_q  <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            bin_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            just_q  <= just_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            bin_q   <= bin_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_rd
        assign req_rdata[g*DW +: DW] = rdata_q[g];
    end

    assign req_ack         = ack_q;
    assign sram_addr       = addr_q;
    assign sram_data_write = wdat_q;
    assign sram_bin        = bin_q;
    assign sram_we         = we_q;
    assign sram_cs         = cs_q;
    assign busy            = (state_q != IDLE);
    assign tmo_err         = tmo_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: scoreboard bench for sram_rr_arbiter with a behavioural SRAM controller model
module tb_sram_rr_arbiter;
    import sram_pkg::*;
    localparam int NP = 3, AW = 22, DW = 32, TMO = TMO_DEF;

    logic              clk = 1'b0, rst;
    logic [NP-1:0]     req_cs, req_we, req_ack;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata, req_rdata;
    logic [NP*4-1:0]   req_bin;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_data_write, sram_data_out;
    logic [3:0]        sram_bin;
    logic              sram_we, sram_cs, sram_ready, busy, tmo_err;

    typedef struct {int port; logic [DW-1:0] rdata;} exp_t;
    exp_t          sb[$];
    logic [DW-1:0] shadow [NP];
    int            vectors = 0, miscompares = 0;
    logic          hang = 1'b0, hold_low = 1'b0;
    int            done_dly = 3, ph, cnt;
    logic [DW-1:0] mdata = '0;

    always #5 clk = ~clk;

    sram_rr_arbiter dut (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_bin(req_bin), .req_ack(req_ack), .req_rdata(req_rdata),
        .sram_addr(sram_addr), .sram_data_write(sram_data_write), .sram_bin(sram_bin),
        .sram_we(sram_we), .sram_cs(sram_cs), .sram_data_out(sram_data_out),
        .sram_ready(sram_ready), .busy(busy), .tmo_err(tmo_err)
    );

    // SRAM controller model: drops ready the edge after it sees cs, raises it done_dly edges later with mdata
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ready <= 1'b1; sram_data_out <= '0; ph <= 0; cnt <= 0;
        end else if (ph == 0) begin
            if (sram_cs && !hang) begin sram_ready <= 1'b0; ph <= 1; cnt <= 1; end
            else sram_ready <= !hold_low;
        end else if (cnt >= done_dly) begin
            sram_ready <= 1'b1; sram_data_out <= mdata; ph <= 0;
        end else cnt <= cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic set_port(input int p, input logic cs, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] b);
        req_cs[p] = cs; req_we[p] = we;
        req_addr[p*AW +: AW] = a; req_wdata[p*DW +: DW] = d; req_bin[p*4 +: 4] = b;
    endtask

    task automatic expect_txn(input int p, input logic keep, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.rdata = keep ? shadow[p] : d;
        shadow[p] = e.rdata;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int budget, input logic [AW-1:0] ea, input logic ewe,
                            input logic [DW-1:0] ed, input logic [3:0] eb,
                            output int port, output int cs_cyc, output int bad, output int multi);
        logic seen;
        port = -1; cs_cyc = 0; bad = 0; multi = 0; seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sram_cs) begin cs_cyc++; seen = 1'b1; end
            if (seen && (sram_addr !== ea || sram_we !== ewe || sram_data_write !== ed || sram_bin !== eb)) bad++;
            if ($countones(req_ack) > 1) multi++;
            if (|req_ack) begin
                for (int p = 0; p < NP; p++) if (req_ack[p]) port = p;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_cs = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_bin = '0;
        for (int p = 0; p < NP; p++) shadow[p] = '0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0 || sram_cs !== 1'b0) begin miscompares++; $display("FAIL reset_busy_cs got %b%b want 00", busy, sram_cs); end
        vectors++; if (req_ack !== '0 || tmo_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack_tmo got %b %b want 0 0", req_ack, tmo_err); end
        vectors++; if (req_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", req_rdata); end
        vectors++; if ({sram_addr, sram_data_write, sram_bin, sram_we} !== '0) begin miscompares++; $display("FAIL reset_cmd got %h %h %h %b want 0", sram_addr, sram_data_write, sram_bin, sram_we); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        int port, csc, bad, multi; exp_t e;
        done_dly = 3; mdata = 32'hDEADBEEF;
        set_port(1, 1'b1, 1'b0, 22'h00010, 32'h0, 4'hF);
        expect_txn(1, 1'b0, mdata);
        wait_ack(60, 22'h00010, 1'b0, 32'h0, 4'hF, port, csc, bad, multi);
        req_cs[1] = 1'b0;
        e = sb.pop_front();
        vectors++; if (port !== e.port) begin miscompares++; $display("FAIL read_port got %0d want %0d", port, e.port); end
        vectors++; if (req_rdata[e.port*DW +: DW] !== e.rdata) begin miscompares++; $display("FAIL read_rdata got %h want %h", req_rdata[e.port*DW +: DW], e.rdata); end
        vectors++; if (csc !== 2) begin miscompares++; $display("FAIL read_cs_cycles got %0d want 2", csc); end
        vectors++; if (bad !== 0 || multi !== 0) begin miscompares++; $display("FAIL read_cmd_stable got bad=%0d multi=%0d want 0 0", bad, multi); end
        @(negedge clk);
        vectors++; if (req_ack !== '0) begin miscompares++; $display("FAIL read_ack_pulse got %b want 000", req_ack); end
    endtask

    task automatic test_write();
        int port, csc, bad, multi; exp_t e;
        mdata = 32'hBAD0BAD0;
        set_port(2, 1'b1, 1'b1, 22'h002AB, 32'h12345678, 4'h3);
        expect_txn(2, 1'b1, '0);
        wait_ack(60, 22'h002AB, 1'b1, 32'h12345678, 4'h3, port, csc, bad, multi);
        req_cs[2] = 1'b0;
        e = sb.pop_front();
        vectors++; if (port !== e.port) begin miscompares++; $display("FAIL write_port got %0d want %0d", port, e.port); end
        vectors++; if (req_rdata[e.port*DW +: DW] !== e.rdata) begin miscompares++; $display("FAIL write_rdata got %h want %h", req_rdata[e.port*DW +: DW], e.rdata); end
        vectors++; if (bad !== 0 || csc !== 2) begin miscompares++; $display("FAIL write_cmd got bad=%0d cs=%0d want 0 2", bad, csc); end
    endtask

    task automatic test_round_robin();
        int port, csc, bad, multi, p; exp_t e;
        rst = 1'b0;
        for (int q = 0; q < NP; q++) begin
            shadow[q] = '0;
            set_port(q, 1'b1, 1'b0, AW'(22'h100 + q), 32'h11111111 * q, 4'(q + 1));
        end
        mdata = 32'hC0DE0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = i % NP;
            expect_txn(p, 1'b0, 32'hC0DE0000 + i);
            wait_ack(60, AW'(22'h100 + p), 1'b0, 32'h11111111 * p, 4'(p + 1), port, csc, bad, multi);
            mdata = 32'hC0DE0000 + i + 1;
            if (i == 5) req_cs = '0;
            e = sb.pop_front();
            vectors++; if (port !== e.port) begin miscompares++; $display("FAIL rr_order[%0d] got %0d want %0d", i, port, e.port); end
            vectors++; if (req_rdata[e.port*DW +: DW] !== e.rdata || bad !== 0 || multi !== 0) begin miscompares++; $display("FAIL rr_data[%0d] got %h bad=%0d multi=%0d want %h", i, req_rdata[e.port*DW +: DW], bad, multi, e.rdata); end
            @(negedge clk);
            vectors++; if (req_ack !== '0) begin miscompares++; $display("FAIL rr_ack_pulse[%0d] got %b want 000", i, req_ack); end
        end
    endtask

    task automatic test_drop_cs();
        int port, csc, bad, multi, acks; exp_t e;
        mdata = 32'h0BADF00D;
        set_port(0, 1'b1, 1'b0, 22'h00055, 32'h0, 4'hF);
        expect_txn(0, 1'b0, mdata);
        for (int n = 0; n < 10 && !busy; n++) @(negedge clk);
        @(negedge clk);
        req_cs[0] = 1'b0;
        wait_ack(60, 22'h00055, 1'b0, 32'h0, 4'hF, port, csc, bad, multi);
        e = sb.pop_front();
        vectors++; if (port !== e.port || req_rdata[e.port*DW +: DW] !== e.rdata) begin miscompares++; $display("FAIL drop_ack got port %0d data %h want %0d %h", port, req_rdata[e.port*DW +: DW], e.port, e.rdata); end
        acks = 0;
        repeat (10) begin @(negedge clk); if (|req_ack) acks++; end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL drop_extra_acks got %0d want 0", acks); end
    endtask

    task automatic test_ready_low();
        int port, csc, bad, multi, act; exp_t e;
        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        mdata = 32'h5A5A1234;
        set_port(0, 1'b1, 1'b0, 22'h00077, 32'h0, 4'hF);
        act = 0;
        repeat (6) begin @(negedge clk); if (busy || sram_cs) act++; end
        vectors++; if (act !== 0) begin miscompares++; $display("FAIL ready_low_grant got %0d active cycles want 0", act); end
        expect_txn(0, 1'b0, mdata);
        hold_low = 1'b0;
        wait_ack(60, 22'h00077, 1'b0, 32'h0, 4'hF, port, csc, bad, multi);
        req_cs[0] = 1'b0;
        e = sb.pop_front();
        vectors++; if (port !== e.port || req_rdata[e.port*DW +: DW] !== e.rdata) begin miscompares++; $display("FAIL ready_low_ack got port %0d data %h want %0d %h", port, req_rdata[e.port*DW +: DW], e.port, e.rdata); end
    endtask

    task automatic test_timeout();
        int port, csc, bad, multi; exp_t e;
        hang = 1'b1;
        set_port(1, 1'b1, 1'b0, 22'h00003, 32'h0, 4'hF);
        expect_txn(1, 1'b1, '0);
        wait_ack(TMO + 100, 22'h00003, 1'b0, 32'h0, 4'hF, port, csc, bad, multi);
        req_cs[1] = 1'b0;
        e = sb.pop_front();
        vectors++; if (port !== e.port || req_rdata[e.port*DW +: DW] !== e.rdata) begin miscompares++; $display("FAIL tmo_ack got port %0d data %h want %0d %h", port, req_rdata[e.port*DW +: DW], e.port, e.rdata); end
        vectors++; if (csc !== TMO) begin miscompares++; $display("FAIL tmo_cs_cycles got %0d want %0d", csc, TMO); end
        vectors++; if (tmo_err !== 1'b1 || sram_cs !== 1'b0) begin miscompares++; $display("FAIL tmo_flag got err=%b cs=%b want 1 0", tmo_err, sram_cs); end
        hang = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0 || tmo_err !== 1'b1) begin miscompares++; $display("FAIL tmo_idle_sticky got busy=%b err=%b want 0 1", busy, tmo_err); end
    endtask

    task automatic test_reset_mid();
        int acks; logic seen, reached;
        hang = 1'b1;
        set_port(2, 1'b1, 1'b0, 22'h00099, 32'h0, 4'hF);
        for (int n = 0; n < 10 && !sram_cs; n++) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (sram_cs !== 1'b0 || busy !== 1'b0 || tmo_err !== 1'b0) begin miscompares++; $display("FAIL rst_issue got cs=%b busy=%b err=%b want 000", sram_cs, busy, tmo_err); end
        vectors++; if (req_rdata !== '0 || sram_addr !== '0 || req_ack !== '0) begin miscompares++; $display("FAIL rst_issue_outs got %h %h %b want 0", req_rdata, sram_addr, req_ack); end
        req_cs = '0; hang = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) shadow[p] = '0;
        done_dly = 8;
        set_port(2, 1'b1, 1'b0, 22'h00099, 32'h0, 4'hF);
        seen = 1'b0; reached = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sram_cs) seen = 1'b1;
            if (seen && busy && !sram_cs) begin reached = 1'b1; break; end
        end
        vectors++; if (reached !== 1'b1) begin miscompares++; $display("FAIL rst_wait_reach got %b want 1", reached); end
        rst = 1'b0;
        #1;
        vectors++; if (sram_cs !== 1'b0 || busy !== 1'b0 || req_ack !== '0 || sram_we !== 1'b0 || sram_addr !== '0) begin miscompares++; $display("FAIL rst_wait_outs got cs=%b busy=%b ack=%b we=%b addr=%h want 0", sram_cs, busy, req_ack, sram_we, sram_addr); end
        req_cs = '0;
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        repeat (20) begin @(negedge clk); if (|req_ack) acks++; end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rst_no_ack got %0d want 0", acks); end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_drop_cs();
        test_ready_low();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
